// File: rtl/mem_port_arbiter.sv
// Shares one line-wide RAM port between the icache (reads) and the dcache (reads/writes).
// One transaction in flight; round-robin or fixed-dcache-priority arbitration.
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LINE_WIDTH = 128,
    parameter bit          RR_ENABLE  = 1'b1
) (
    input  logic                  clk,
    input  logic                  RESET,

    input  logic                  ic_req_valid,
    input  logic [ADDR_WIDTH-1:0] ic_req_addr,
    output logic                  ic_req_ready,
    output logic                  ic_rsp_valid,
    output logic [LINE_WIDTH-1:0] ic_rsp_data,

    input  logic                  dc_req_valid,
    input  logic                  dc_req_rw,
    input  logic [ADDR_WIDTH-1:0] dc_req_addr,
    input  logic [LINE_WIDTH-1:0] dc_req_wdata,
    output logic                  dc_req_ready,
    output logic                  dc_rsp_valid,
    output logic [LINE_WIDTH-1:0] dc_rsp_data,

    output logic [ADDR_WIDTH-1:0] ram_read_addr,
    output logic                  ram_read_addr_valid,
    input  logic                  ram_read_addr_ready,
    input  logic [LINE_WIDTH-1:0] ram_read_data,
    input  logic                  ram_read_data_valid,

    output logic [ADDR_WIDTH-1:0] ram_write_addr,
    output logic [LINE_WIDTH-1:0] ram_write_data,
    output logic                  ram_write_addr_valid,
    input  logic                  ram_write_addr_ready,
    input  logic                  ram_write_resp_valid,

    output logic                  busy,
    output logic                  owner
);

    localparam int unsigned OFFSET_BITS = 4;
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'((2 ** OFFSET_BITS) - 1);
    localparam logic OWNER_IC = 1'b0;
    localparam logic OWNER_DC = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_RSP,
        S_RESPOND
    } state_t;

    state_t                r_state;
    logic                  r_owner;
    logic                  r_rw;
    logic                  r_last_grant;
    logic                  r_busy;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LINE_WIDTH-1:0] r_wdata;
    logic                  r_ic_req_ready;
    logic                  r_dc_req_ready;
    logic                  r_ic_rsp_valid;
    logic                  r_dc_rsp_valid;
    logic [LINE_WIDTH-1:0] r_ic_rsp_data;
    logic [LINE_WIDTH-1:0] r_dc_rsp_data;
    logic                  r_ram_rd_valid;
    logic                  r_ram_wr_valid;

    logic                  w_any_req;
    logic                  w_pick_dc;
    logic                  w_grant_wr;
    logic [ADDR_WIDTH-1:0] w_grant_addr;

    // Tie goes to the requester that was not served last (or always dcache when RR is off)
    assign w_any_req    = ic_req_valid | dc_req_valid;
    assign w_pick_dc    = dc_req_valid &
                          (~ic_req_valid | ~RR_ENABLE | (r_last_grant == OWNER_IC));
    assign w_grant_wr   = w_pick_dc & dc_req_rw;
    assign w_grant_addr = (w_pick_dc ? dc_req_addr : ic_req_addr) & LINE_MASK;

    always_ff @(posedge clk) begin
        if (RESET) begin
            r_state        <= S_IDLE;
            r_owner        <= OWNER_IC;
            r_rw           <= 1'b0;
            r_last_grant   <= OWNER_IC;
            r_busy         <= 1'b0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_ic_req_ready <= 1'b0;
            r_dc_req_ready <= 1'b0;
            r_ic_rsp_valid <= 1'b0;
            r_dc_rsp_valid <= 1'b0;
            r_ic_rsp_data  <= '0;
            r_dc_rsp_data  <= '0;
            r_ram_rd_valid <= 1'b0;
            r_ram_wr_valid <= 1'b0;
        end else begin
            r_ic_req_ready <= 1'b0;
            r_dc_req_ready <= 1'b0;
            r_ic_rsp_valid <= 1'b0;
            r_dc_rsp_valid <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_ic_req_ready <= ~w_pick_dc;
                        r_dc_req_ready <= w_pick_dc;
                        r_owner        <= w_pick_dc;
                        r_rw           <= w_grant_wr;
                        r_addr         <= w_grant_addr;
                        r_wdata        <= dc_req_wdata;
                        r_ram_rd_valid <= ~w_grant_wr;
                        r_ram_wr_valid <= w_grant_wr;
                        r_busy         <= 1'b1;
                        r_state        <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    if ((r_rw && ram_write_addr_ready) || (!r_rw && ram_read_addr_ready)) begin
                        r_ram_rd_valid <= 1'b0;
                        r_ram_wr_valid <= 1'b0;
                        r_state        <= S_WAIT_RSP;
                    end
                end

                // Only the response type matching the issued command is accepted
                S_WAIT_RSP: begin
                    if (r_rw) begin
                        if (ram_write_resp_valid) begin
                            r_state <= S_RESPOND;
                        end
                    end else if (ram_read_data_valid) begin
                        if (r_owner == OWNER_DC) begin
                            r_dc_rsp_data <= ram_read_data;
                        end else begin
                            r_ic_rsp_data <= ram_read_data;
                        end
                        r_state <= S_RESPOND;
                    end
                end

                S_RESPOND: begin
                    r_ic_rsp_valid <= (r_owner == OWNER_IC);
                    r_dc_rsp_valid <= (r_owner == OWNER_DC);
                    r_last_grant   <= r_owner;
                    r_busy         <= 1'b0;
                    r_state        <= S_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ic_req_ready         = r_ic_req_ready;
    assign dc_req_ready         = r_dc_req_ready;
    assign ic_rsp_valid         = r_ic_rsp_valid;
    assign dc_rsp_valid         = r_dc_rsp_valid;
    assign ic_rsp_data          = r_ic_rsp_data;
    assign dc_rsp_data          = r_dc_rsp_data;
    assign ram_read_addr        = r_addr;
    assign ram_write_addr       = r_addr;
    assign ram_write_data       = r_wdata;
    assign ram_read_addr_valid  = r_ram_rd_valid;
    assign ram_write_addr_valid = r_ram_wr_valid;
    assign busy                 = r_busy;
    assign owner                = r_owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table with a response scoreboard, plus reset and
// fixed-priority sequences on a second instance.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned LW = 128;
    localparam logic [LW-1:0] F_DATA = 128'h0F0F_1111_2222_3333_4444_5555_6666_F0F0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          RESET;
    logic          ic_req_valid, ic_req_ready, ic_rsp_valid;
    logic [AW-1:0] ic_req_addr;
    logic [LW-1:0] ic_rsp_data;
    logic          dc_req_valid, dc_req_rw, dc_req_ready, dc_rsp_valid;
    logic [AW-1:0] dc_req_addr;
    logic [LW-1:0] dc_req_wdata, dc_rsp_data;
    logic [AW-1:0] ram_read_addr, ram_write_addr;
    logic          ram_read_addr_valid, ram_read_addr_ready, ram_read_data_valid;
    logic [LW-1:0] ram_read_data, ram_write_data;
    logic          ram_write_addr_valid, ram_write_addr_ready, ram_write_resp_valid;
    logic          busy, owner;

    logic          f_ic_req_valid, f_ic_req_ready, f_ic_rsp_valid;
    logic          f_dc_req_valid, f_dc_req_ready, f_dc_rsp_valid;
    logic [LW-1:0] f_ic_rsp_data, f_dc_rsp_data, f_ram_write_data;
    logic [AW-1:0] f_ram_read_addr, f_ram_write_addr;
    logic          f_ram_read_addr_valid, f_ram_write_addr_valid, f_busy, f_owner;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .RR_ENABLE(1'b1)) u_dut (
        .clk(clk), .RESET(RESET),
        .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
        .ic_rsp_valid(ic_rsp_valid), .ic_rsp_data(ic_rsp_data),
        .dc_req_valid(dc_req_valid), .dc_req_rw(dc_req_rw), .dc_req_addr(dc_req_addr),
        .dc_req_wdata(dc_req_wdata), .dc_req_ready(dc_req_ready),
        .dc_rsp_valid(dc_rsp_valid), .dc_rsp_data(dc_rsp_data),
        .ram_read_addr(ram_read_addr), .ram_read_addr_valid(ram_read_addr_valid),
        .ram_read_addr_ready(ram_read_addr_ready), .ram_read_data(ram_read_data),
        .ram_read_data_valid(ram_read_data_valid),
        .ram_write_addr(ram_write_addr), .ram_write_data(ram_write_data),
        .ram_write_addr_valid(ram_write_addr_valid), .ram_write_addr_ready(ram_write_addr_ready),
        .ram_write_resp_valid(ram_write_resp_valid),
        .busy(busy), .owner(owner)
    );

    // Fixed-priority instance against an always-ready RAM
    mem_port_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .RR_ENABLE(1'b0)) u_fix (
        .clk(clk), .RESET(RESET),
        .ic_req_valid(f_ic_req_valid), .ic_req_addr(32'h0000_0088), .ic_req_ready(f_ic_req_ready),
        .ic_rsp_valid(f_ic_rsp_valid), .ic_rsp_data(f_ic_rsp_data),
        .dc_req_valid(f_dc_req_valid), .dc_req_rw(1'b0), .dc_req_addr(32'h0000_0044),
        .dc_req_wdata(128'h0), .dc_req_ready(f_dc_req_ready),
        .dc_rsp_valid(f_dc_rsp_valid), .dc_rsp_data(f_dc_rsp_data),
        .ram_read_addr(f_ram_read_addr), .ram_read_addr_valid(f_ram_read_addr_valid),
        .ram_read_addr_ready(1'b1), .ram_read_data(F_DATA), .ram_read_data_valid(1'b1),
        .ram_write_addr(f_ram_write_addr), .ram_write_data(f_ram_write_data),
        .ram_write_addr_valid(f_ram_write_addr_valid), .ram_write_addr_ready(1'b1),
        .ram_write_resp_valid(1'b1),
        .busy(f_busy), .owner(f_owner)
    );

    typedef struct {
        logic          ic_v;
        logic          dc_v;
        logic          dc_rw;
        logic [AW-1:0] ic_addr;
        logic [AW-1:0] dc_addr;
        logic [LW-1:0] wdata;
        logic [LW-1:0] rdata;
        int            rdy_dly;
        int            rsp_dly;
        logic          wrong;
        logic          exp_dc;
        logic [AW-1:0] exp_addr;
    } vec_t;

    typedef struct {
        logic          is_dc;
        logic          chk_data;
        logic [LW-1:0] data;
    } exp_t;

    exp_t          sb[$];
    vec_t          vecs[10];
    int            checks   = 0;
    int            failures = 0;
    logic [LW-1:0] m_ic = '0;
    logic [LW-1:0] m_dc = '0;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic icv, input logic dcv, input logic rw,
                                input logic [AW-1:0] ia, input logic [AW-1:0] da,
                                input logic [LW-1:0] wd, input logic [LW-1:0] rd,
                                input int rdy, input int rsp, input logic wr,
                                input logic edc, input logic [AW-1:0] ea);
        vec_t v;
        v.ic_v = icv; v.dc_v = dcv; v.dc_rw = rw; v.ic_addr = ia; v.dc_addr = da;
        v.wdata = wd; v.rdata = rd; v.rdy_dly = rdy; v.rsp_dly = rsp; v.wrong = wr;
        v.exp_dc = edc; v.exp_addr = ea;
        return v;
    endfunction

    // Scoreboard: every response pulse must match the oldest outstanding grant
    always @(negedge clk) begin
        exp_t e;
        if (RESET) begin
            sb.delete();
            m_ic <= '0;
            m_dc <= '0;
        end else if (ic_rsp_valid || dc_rsp_valid) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", LW'({ic_rsp_valid, dc_rsp_valid}), '0);
            end else begin
                e = sb.pop_front();
                chk("rsp_owner", LW'({ic_rsp_valid, dc_rsp_valid}), e.is_dc ? LW'(2'b01) : LW'(2'b10));
                if (e.is_dc) begin
                    if (e.chk_data) begin
                        chk("dc_rsp_data", dc_rsp_data, e.data);
                        m_dc <= e.data;
                    end
                    chk("ic_data_stable", ic_rsp_data, m_ic);
                end else begin
                    chk("ic_rsp_data", ic_rsp_data, e.data);
                    m_ic <= e.data;
                    chk("dc_data_stable", dc_rsp_data, m_dc);
                end
            end
        end
    end

    task automatic serve_ram(input vec_t v, input int idx);
        logic rw;
        rw = v.exp_dc & v.dc_rw;
        chk($sformatf("v%0d_ram_valids", idx), LW'({ram_read_addr_valid, ram_write_addr_valid}), LW'({~rw, rw}));
        chk($sformatf("v%0d_ram_addr", idx), LW'(rw ? ram_write_addr : ram_read_addr), LW'(v.exp_addr));
        if (rw) chk($sformatf("v%0d_ram_wdata", idx), ram_write_data, v.wdata);
        repeat (v.rdy_dly) @(negedge clk);
        if (v.rdy_dly > 0)
            chk($sformatf("v%0d_valid_hold", idx), LW'({ram_read_addr_valid, ram_write_addr_valid}), LW'({~rw, rw}));
        if (rw) ram_write_addr_ready = 1'b1; else ram_read_addr_ready = 1'b1;
        @(negedge clk);
        ram_write_addr_ready = 1'b0;
        ram_read_addr_ready  = 1'b0;
        chk($sformatf("v%0d_valid_drop", idx), LW'({ram_read_addr_valid, ram_write_addr_valid}), '0);
        chk($sformatf("v%0d_no_ready_busy", idx), LW'({ic_req_ready, dc_req_ready}), '0);
        if (v.wrong) begin
            if (rw) ram_read_data_valid = 1'b1; else ram_write_resp_valid = 1'b1;
            @(negedge clk);
            ram_read_data_valid  = 1'b0;
            ram_write_resp_valid = 1'b0;
        end
        repeat (v.rsp_dly) @(negedge clk);
        chk($sformatf("v%0d_busy_wait", idx), LW'(busy), LW'(1'b1));
        if (rw) begin
            ram_write_resp_valid = 1'b1;
        end else begin
            ram_read_data       = v.rdata;
            ram_read_data_valid = 1'b1;
        end
        @(negedge clk);
        ram_read_data_valid  = 1'b0;
        ram_write_resp_valid = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d_busy_done", idx), LW'(busy), '0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic got;
        exp_t e;
        ic_req_valid = v.ic_v;
        ic_req_addr  = v.ic_addr;
        dc_req_valid = v.dc_v;
        dc_req_rw    = v.dc_rw;
        dc_req_addr  = v.dc_addr;
        dc_req_wdata = v.wdata;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ic_req_ready || dc_req_ready) begin
                got = 1'b1;
                break;
            end
        end
        chk($sformatf("v%0d_grant_seen", idx), LW'(got), LW'(1'b1));
        if (!got) begin
            ic_req_valid = 1'b0;
            dc_req_valid = 1'b0;
            return;
        end
        chk($sformatf("v%0d_grant", idx), LW'({ic_req_ready, dc_req_ready}), v.exp_dc ? LW'(2'b01) : LW'(2'b10));
        chk($sformatf("v%0d_owner", idx), LW'(owner), LW'(v.exp_dc));
        chk($sformatf("v%0d_busy", idx), LW'(busy), LW'(1'b1));
        if (v.exp_dc) dc_req_valid = 1'b0; else ic_req_valid = 1'b0;
        e.is_dc    = v.exp_dc;
        e.chk_data = ~(v.exp_dc & v.dc_rw);
        e.data     = v.rdata;
        sb.push_back(e);
        serve_ram(v, idx);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int f_ic_g, f_dc_g, f_ic_r, f_dc_r, f_rd, f_wr;

        // ic_v dc_v rw  ic_addr  dc_addr  wdata  rdata  rdy rsp wrong exp_dc exp_addr
        vecs[0] = mk(1, 1, 0, 32'h0000_1234, 32'h0000_4444, '0, 128'h1111_0000_0000_0000_0000_0000_0000_0001, 0, 0, 0, 1, 32'h0000_4440);
        vecs[1] = mk(1, 0, 0, 32'h0000_1234, '0, '0, 128'hDEAD_0011_2233_4455_6677_8899_AABB_BEEF, 0, 0, 0, 0, 32'h0000_1230);
        vecs[2] = mk(0, 1, 1, '0, 32'h0000_2008, {16{8'hA5}}, '0, 4, 1, 0, 1, 32'h0000_2000);
        vecs[3] = mk(1, 1, 0, 32'h0000_5678, 32'h0000_300F, '0, 128'h3333_CAFE_0000_0000_0000_0000_0000_0003, 1, 0, 0, 0, 32'h0000_5670);
        vecs[4] = mk(0, 1, 0, '0, 32'h0000_300F, '0, 128'h4444_F00D_0000_0000_0000_0000_0000_0004, 1, 3, 1, 1, 32'h0000_3000);
        vecs[5] = mk(1, 0, 0, 32'hFFFF_FFFF, '0, '0, 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA, 2, 2, 0, 0, 32'hFFFF_FFF0);
        vecs[6] = mk(1, 1, 1, 32'h0000_9ABC, 32'h0000_7FFC, 128'h6666_0123_4567_89AB_CDEF_0000_1111_2222, '0, 0, 0, 0, 1, 32'h0000_7FF0);
        vecs[7] = mk(1, 0, 0, 32'h0000_9ABC, '0, '0, 128'h7777_0000_0000_0000_0000_0000_0000_0007, 0, 0, 0, 0, 32'h0000_9AB0);
        vecs[8] = mk(1, 1, 0, 32'h0000_0040, 32'hABC0_0004, '0, 128'h8888_0000_0000_0000_0000_0000_0000_0008, 0, 0, 0, 1, 32'hABC0_0000);
        vecs[9] = mk(1, 0, 0, 32'h0000_0040, '0, '0, 128'h9999_0000_0000_0000_0000_0000_0000_0009, 0, 1, 1, 0, 32'h0000_0040);

        RESET = 1'b1;
        ic_req_valid = 1'b0; ic_req_addr = '0;
        dc_req_valid = 1'b0; dc_req_rw = 1'b0; dc_req_addr = '0; dc_req_wdata = '0;
        ram_read_addr_ready = 1'b0; ram_read_data = '0; ram_read_data_valid = 1'b0;
        ram_write_addr_ready = 1'b0; ram_write_resp_valid = 1'b0;
        f_ic_req_valid = 1'b0; f_dc_req_valid = 1'b0;
        repeat (3) @(negedge clk);
        RESET = 1'b0;
        @(negedge clk);

        chk("rst_req_ready", LW'({ic_req_ready, dc_req_ready}), '0);
        chk("rst_rsp_valid", LW'({ic_rsp_valid, dc_rsp_valid}), '0);
        chk("rst_ram_valid", LW'({ram_read_addr_valid, ram_write_addr_valid}), '0);
        chk("rst_busy_owner", LW'({busy, owner}), '0);
        chk("rst_ic_data", ic_rsp_data, '0);
        chk("rst_dc_data", dc_rsp_data, '0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Reset while waiting on a read; the late read data must be dropped
        ic_req_valid = 1'b1;
        ic_req_addr  = 32'h0000_0100;
        @(negedge clk);
        chk("mr_grant", LW'({ic_req_ready, dc_req_ready}), LW'(2'b10));
        ic_req_valid = 1'b0;
        ram_read_addr_ready = 1'b1;
        @(negedge clk);
        ram_read_addr_ready = 1'b0;
        chk("mr_in_wait", LW'(busy), LW'(1'b1));
        RESET = 1'b1;
        repeat (2) @(negedge clk);
        RESET = 1'b0;
        ram_read_data = 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0;
        ram_read_data_valid = 1'b1;
        @(negedge clk);
        ram_read_data_valid = 1'b0;
        chk("mr_busy", LW'({busy, owner}), '0);
        chk("mr_ic_data", ic_rsp_data, '0);
        chk("mr_dc_data", dc_rsp_data, '0);
        repeat (4) @(negedge clk);
        chk("mr_still_idle", LW'({busy, ic_rsp_valid, dc_rsp_valid}), '0);

        for (int i = 8; i < 10; i++) run_vec(vecs[i], i);

        // Fixed dcache priority with both requesters held for three transactions
        f_ic_req_valid = 1'b1;
        f_dc_req_valid = 1'b1;
        f_ic_g = 0; f_dc_g = 0; f_ic_r = 0; f_dc_r = 0; f_rd = 0; f_wr = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (f_ic_req_ready) f_ic_g++;
            if (f_dc_req_ready) begin
                f_dc_g++;
                chk("fix_owner", LW'(f_owner), LW'(1'b1));
            end
            if (f_ic_rsp_valid) f_ic_r++;
            if (f_dc_rsp_valid) f_dc_r++;
            if (f_ram_read_addr_valid) f_rd++;
            if (f_ram_write_addr_valid) f_wr++;
        end
        f_ic_req_valid = 1'b0;
        f_dc_req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("fix_dc_grants", LW'(f_dc_g), LW'(3));
        chk("fix_ic_grants", LW'(f_ic_g), '0);
        chk("fix_rsp_counts", LW'({f_ic_r[7:0], f_dc_r[7:0]}), LW'(16'h0003));
        chk("fix_ram_cmds", LW'({f_rd[7:0], f_wr[7:0]}), LW'(16'h0300));
        chk("fix_ram_addrs", LW'({f_ram_read_addr, f_ram_write_addr}), LW'(64'h0000_0040_0000_0040));
        chk("fix_wdata", f_ram_write_data, '0);
        chk("fix_dc_data", f_dc_rsp_data, F_DATA);
        chk("fix_ic_data", f_ic_rsp_data, '0);
        chk("fix_idle", LW'(f_busy), '0);

        repeat (3) @(negedge clk);
        chk("sb_drain", LW'(sb.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single line-wide RAM port between the instruction cache (read-only) and the data cache (read/write).
- Sits between both L1 controllers and the RAM controller.
- One transaction in flight at a time; the granted request is latched and replayed to RAM; the response is returned in a registered stage to the owner only.
- Arbitration is round-robin, or fixed dcache priority when configured.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- LINE_WIDTH, 128, cache line width in bits.
- RR_ENABLE, 1, 1 = round-robin; 0 = dcache always wins ties.

Ports:
- clk  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- ic_req_valid  in  1  icache line read request
- ic_req_addr  in  ADDR_WIDTH  icache byte address
- ic_req_ready  out  1  one-cycle pulse: icache request latched
- ic_rsp_valid  out  1  one-cycle pulse: ic_rsp_data valid
- ic_rsp_data  out  LINE_WIDTH  returned line
- dc_req_valid  in  1  dcache request
- dc_req_rw  in  1  1 = write line, 0 = read line
- dc_req_addr  in  ADDR_WIDTH  dcache byte address
- dc_req_wdata  in  LINE_WIDTH  writeback line
- dc_req_ready  out  1  one-cycle pulse: dcache request latched
- dc_rsp_valid  out  1  one-cycle pulse: read data, or write completed
- dc_rsp_data  out  LINE_WIDTH  returned line; reads only
- ram_read_addr  out  ADDR_WIDTH  line-aligned read address
- ram_read_addr_valid  out  1  read address valid
- ram_read_addr_ready  in  1  RAM accepts read address
- ram_read_data  in  LINE_WIDTH  read line
- ram_read_data_valid  in  1  read line valid
- ram_write_addr  out  ADDR_WIDTH  line-aligned write address
- ram_write_data  out  LINE_WIDTH  write line
- ram_write_addr_valid  out  1  write address/data valid
- ram_write_addr_ready  in  1  RAM accepts write
- ram_write_resp_valid  in  1  write complete
- busy  out  1  FSM not in IDLE
- owner  out  1  0 = icache, 1 = dcache; valid while busy

Behaviour:
Reset:
- Synchronous, checked before any other state update; wins over every event in the same cycle.
- State → IDLE. All valid/ready outputs and busy → 0; owner → 0; rsp_data registers → 0.
- last_grant → icache, so the first tie goes to dcache.
- Reset mid-transaction abandons it without any response. A RAM response that arrives after reset, while IDLE, is ignored.

FSM states: IDLE, ISSUE, WAIT_RSP, RESPOND.

IDLE:
- If any req_valid is high, select a winner:
  - RR_ENABLE = 1: on a tie, the winner is the requester that is not last_grant.
  - RR_ENABLE = 0: dcache wins ties.
  - A single requester always wins.
- In the same cycle:
  - pulse the winner's req_ready;
  - latch owner, rw (forced 0 for icache), addr with bits [3:0] cleared, and wdata;
  - go to ISSUE.
- The loser is not acknowledged and must hold its request.

ISSUE:
- Drive ram_read_addr_valid (rw = 0) or ram_write_addr_valid (rw = 1) from the latched registers.
- ram_read_addr and ram_write_addr both carry the latched address; ram_write_data carries the latched wdata.
- Hold the valid until the matching ready is sampled high, then deassert it next cycle and go to WAIT_RSP.
- The other RAM valid stays 0.

WAIT_RSP:
- For a read, wait for ram_read_data_valid: capture ram_read_data into the owner's rsp_data register, then go to RESPOND.
- For a write, wait for ram_write_resp_valid, then go to RESPOND.
- A response of the wrong type is ignored. No timeout.

RESPOND:
- Assert the owner's rsp_valid for exactly one cycle.
- rsp_data stays stable until the next response to that requester.
- Set last_grant to owner; go to IDLE.

Timing and handshake rules:
- Minimum latency: accepted at cycle 0, RAM ready at cycle 1, RAM response at cycle 2, rsp_valid at cycle 3.
- New requests are never accepted while busy. req_ready is 0 outside IDLE.
- A requester may drop req_valid after its req_ready pulse.
- A requester must not drop req_valid before its req_ready pulse. If it does, the request is simply not granted.
- rsp_valid is never asserted to the non-owner.
- RAM responses arriving in IDLE or ISSUE are dropped.

Test Plan:
- Single icache read: ic_req addr 0x0000_1234 → ic_req_ready at cycle 0; ram_read_addr = 0x0000_1230 held until ready; RAM returns 0xDEAD…BEEF → ic_rsp_valid for 1 cycle with that data; dc_rsp_valid stays 0.
- Dcache writeback: dc_req_rw = 1, addr 0x0000_2008, wdata 0xA5…A5; ram_write_addr_ready delayed 4 cycles → ram_write_addr_valid held 4 cycles, addr 0x0000_2000; write_resp → dc_rsp_valid pulse.
- Tie with RR_ENABLE = 1: both requests valid after reset → dcache served first, then icache. Then dcache re-requests alone → dcache served. Both valid again after an icache grant → dcache wins.
- Tie with RR_ENABLE = 0: both valid continuously for 3 transactions → dcache granted all 3; ic_req_ready stays 0.
- RESET asserted in WAIT_RSP, with ram_read_data_valid arriving on the next cycle → no rsp_valid to either requester; busy = 0; the next request is handled normally.
- Wrong-type response: during a read, ram_write_resp_valid is pulsed → ignored; the FSM stays in WAIT_RSP until ram_read_data_valid.
